// File: rtl/rip_fifo_sync_if.sv
// rip_fifo_sync_if
// Handshake and status bundle for rip_fifo_sync. Clock and reset stay outside
// the bundle as plain ports on the FIFO.
//
// Signals:
//   flush      producer/consumer -> FIFO  synchronous clear of contents and sticky flags
//   w_en       producer -> FIFO           write request
//   w_data     producer -> FIFO           write data
//   w_full     FIFO -> producer           count == DEPTH
//   w_afull    FIFO -> producer           count >= AFULL_THRESH
//   r_en       consumer -> FIFO           read request / pop
//   r_data     FIFO -> consumer           read data
//   r_valid    FIFO -> consumer           r_data is valid
//   r_empty    FIFO -> consumer           count == 0
//   r_aempty   FIFO -> consumer           count <= AEMPTY_THRESH
//   count      FIFO -> both               occupancy 0..DEPTH
//   overflow   FIFO -> both               sticky: write attempted while full
//   underflow  FIFO -> both               sticky: read attempted while empty
//
// Modports: master = the side driving requests, slave = the FIFO itself.
interface rip_fifo_sync_if #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 8
);
    logic                  flush;
    logic                  w_en;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  w_full;
    logic                  w_afull;
    logic                  r_en;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  r_empty;
    logic                  r_aempty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output flush, w_en, w_data, r_en,
        input  w_full, w_afull, r_data, r_valid, r_empty, r_aempty,
               count, overflow, underflow
    );

    modport slave (
        input  flush, w_en, w_data, r_en,
        output w_full, w_afull, r_data, r_valid, r_empty, r_aempty,
               count, overflow, underflow
    );
endinterface

// File: rtl/rip_fifo_sync.sv
// rip_fifo_sync
// Single-clock FIFO for buffering between pipeline stages that share clk.
// Provides occupancy count, almost-full / almost-empty flags, sticky
// overflow / underflow flags and a synchronous flush. The read port is either
// first-word-fall-through (FWFT=1) or registered (FWFT=0).
//
// Ports:
//   clk    input   clock, all logic on posedge
//   rst_n  input   synchronous active-low reset
//   bus    slave   rip_fifo_sync_if bundle (flush, write port, read port,
//                  count and status flags)
module rip_fifo_sync #(
    parameter int DATA_WIDTH    = 128,
    parameter int ADDR_WIDTH    = 8,
    parameter bit FWFT          = 1'b1,
    parameter int AFULL_THRESH  = (2 ** ADDR_WIDTH) - 1,
    parameter int AEMPTY_THRESH = 1
) (
    input logic            clk,
    input logic            rst_n,
    rip_fifo_sync_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH + 1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH + 1)'(AEMPTY_THRESH);
    localparam logic [ADDR_WIDTH:0] ONE_C    = (ADDR_WIDTH + 1)'(1);

    // Out-of-range thresholds would make a flag stuck or meaningless, so they
    // stop elaboration instead of producing a silently broken FIFO.
    generate
        if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
            initial $fatal(1, "rip_fifo_sync: AFULL_THRESH=%0d outside 1..%0d",
                           AFULL_THRESH, DEPTH);
        end
        if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
            initial $fatal(1, "rip_fifo_sync: AEMPTY_THRESH=%0d outside 0..%0d",
                           AEMPTY_THRESH, DEPTH - 1);
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   w_ptr;
    logic [ADDR_WIDTH:0]   r_ptr;
    logic [ADDR_WIDTH:0]   count_q;
    logic                  overflow_q;
    logic                  underflow_q;
    logic                  full;
    logic                  empty;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic [ADDR_WIDTH-1:0] r_idx;

    assign full   = (count_q == DEPTH_C);
    assign empty  = (count_q == '0);
    assign wr_acc = bus.w_en && !full;
    assign rd_acc = bus.r_en && !empty;
    assign w_idx  = w_ptr[ADDR_WIDTH-1:0];
    assign r_idx  = r_ptr[ADDR_WIDTH-1:0];

    // Storage is never reset; a flush-cycle write is dropped so a flushed
    // FIFO cannot leak the word presented alongside flush.
    always_ff @(posedge clk) begin
        if (rst_n && !bus.flush && wr_acc) begin
            mem[w_idx] <= bus.w_data;
        end
    end

    // Pointers, registered count and sticky flags. Reset and flush clear the
    // same state; requests are ignored in either case.
    always_ff @(posedge clk) begin
        if (!rst_n || bus.flush) begin
            w_ptr       <= '0;
            r_ptr       <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_acc) begin
                w_ptr <= w_ptr + ONE_C;
            end
            if (rd_acc) begin
                r_ptr <= r_ptr + ONE_C;
            end
            unique case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + ONE_C;
                2'b01:   count_q <= count_q - ONE_C;
                default: count_q <= count_q;
            endcase
            if (bus.w_en && full) begin
                overflow_q <= 1'b1;
            end
            if (bus.r_en && empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign bus.count     = count_q;
    assign bus.w_full    = full;
    assign bus.w_afull   = (count_q >= AFULL_C);
    assign bus.r_empty   = empty;
    assign bus.r_aempty  = (count_q <= AEMPTY_C);
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;

    generate
        if (FWFT) begin : g_fwft
            // Head word is presented directly from storage; meaningless when empty.
            assign bus.r_data  = mem[r_idx];
            assign bus.r_valid = !empty;
        end else begin : g_reg_read
            logic [DATA_WIDTH-1:0] r_data_q;
            logic                  r_valid_q;

            // r_data only moves on an accepted read, so it keeps the last
            // popped word across idle cycles and flushes.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_data_q  <= '0;
                    r_valid_q <= 1'b0;
                end else if (bus.flush) begin
                    r_valid_q <= 1'b0;
                end else begin
                    r_valid_q <= rd_acc;
                    if (rd_acc) begin
                        r_data_q <= mem[r_idx];
                    end
                end
            end

            assign bus.r_data  = r_data_q;
            assign bus.r_valid = r_valid_q;
        end
    endgenerate
endmodule
